// File: rtl/led_pattern_gen.sv
// LED frame generator: FILL / BOUNCE / ROTATE / BLINK animations stepped by a prescaled frame tick.
// Optional brightness PWM on the LED outputs is enabled by defining LED_PAT_PWM_EN.
module led_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int DIV_W = 8,
  parameter int PWM_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fc,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             hold,
  input  logic             restart,
`ifdef LED_PAT_PWM_EN
  input  logic [PWM_W-1:0] brightness,
`endif
  output logic [WIDTH-1:0] led,
  output logic             wrap
);

  typedef enum logic [1:0] {FILL, BOUNCE, ROTATE, BLINK} mode_t;

  mode_t            cur_mode;
  logic [WIDTH-1:0] frame;
  logic             dir;
  logic [DIV_W-1:0] cnt;

  logic [WIDTH-1:0] nxt_frame;
  logic             nxt_dir;
  logic             nxt_wrap;

  if (WIDTH < 2 || PWM_W < 1) begin : g_param_check
    $error("led_pattern_gen: WIDTH must be >= 2 and PWM_W >= 1");
  end

  function automatic logic [WIDTH-1:0] start_frame(input mode_t m);
    if (m == BOUNCE || m == ROTATE)
      return {1'b1, {(WIDTH-1){1'b0}}};
    return '0;
  endfunction

  // Next frame for a single animation step; dir flips at the ends of FILL and BOUNCE.
  always_comb begin
    nxt_frame = frame;
    nxt_dir   = dir;
    nxt_wrap  = 1'b0;
    case (cur_mode)
      FILL: begin
        if (!dir) begin
          nxt_frame = {1'b1, frame[WIDTH-1:1]};
          if (&nxt_frame) nxt_dir = 1'b1;
        end else begin
          nxt_frame = frame << 1;
          if (nxt_frame == '0) begin
            nxt_dir  = 1'b0;
            nxt_wrap = 1'b1;
          end
        end
      end
      BOUNCE: begin
        if (!dir) begin
          nxt_frame = frame >> 1;
          if (nxt_frame[0]) nxt_dir = 1'b1;
        end else begin
          nxt_frame = frame << 1;
          if (nxt_frame[WIDTH-1]) begin
            nxt_dir  = 1'b0;
            nxt_wrap = 1'b1;
          end
        end
      end
      ROTATE: begin
        nxt_frame = {frame[0], frame[WIDTH-1:1]};
        nxt_wrap  = frame[0];
      end
      BLINK: begin
        nxt_frame = ~frame;
        nxt_wrap  = &frame;
      end
      default: ;
    endcase
  end

  // Mode change beats restart beats hold beats a prescaled step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_mode <= FILL;
      frame    <= '0;
      dir      <= 1'b0;
      cnt      <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (mode_t'(mode) != cur_mode) begin
        cur_mode <= mode_t'(mode);
        frame    <= start_frame(mode_t'(mode));
        dir      <= 1'b0;
        cnt      <= '0;
      end else if (restart) begin
        frame <= start_frame(cur_mode);
        dir   <= 1'b0;
        cnt   <= '0;
      end else if (!hold && fc) begin
        // >= lets a lowered div take effect on the very next tick.
        if (cnt >= div) begin
          frame <= nxt_frame;
          dir   <= nxt_dir;
          wrap  <= nxt_wrap;
          cnt   <= '0;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

`ifdef LED_PAT_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm_cnt <= '0;
    else      pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  assign led = frame & {WIDTH{pwm_cnt < brightness}};
`else
  assign led = frame;
`endif

endmodule
